// File: rtl/jelly_rtos_pkg.sv
// Shared opcodes, response and wakeup codes for the Jelly RTOS blocks.
// Used by the command decoder, the semaphore bank and the ready queue.
package jelly_rtos_pkg;

    typedef enum logic [1:0] {
        OP_SIGNAL = 2'd0,
        OP_WAIT   = 2'd1,
        OP_POLL   = 2'd2,
        OP_CANCEL = 2'd3
    } cmd_op_e;

    typedef enum logic [1:0] {
        RSP_OK     = 2'd0,
        RSP_QUEUED = 2'd1,
        RSP_FAIL   = 2'd2,
        RSP_ERROR  = 2'd3
    } rsp_code_e;

    typedef enum logic [1:0] {
        WUP_SIGNALED = 2'd0,
        WUP_TIMEOUT  = 2'd1,
        WUP_CANCELED = 2'd2
    } wup_code_e;

    // Wait-forever timeout; slice to the local timeout width.
    localparam logic [63:0] TMO_FEVR = '1;

endpackage

// File: rtl/jelly_rtos_pri_select.sv
// Combinational argmin over a masked priority vector.
// Ties resolve to the lowest index.
module jelly_rtos_pri_select #(
    parameter int N         = 16,
    parameter int PRI_WIDTH = 4,
    parameter int ID_WIDTH  = 4
) (
    input  logic [N-1:0]           valid,
    input  logic [N*PRI_WIDTH-1:0] pri,
    output logic [ID_WIDTH-1:0]    id,
    output logic                   found
);

    logic [PRI_WIDTH-1:0] best_pri;

    always_comb begin
        id       = '0;
        found    = 1'b0;
        best_pri = '0;
        for (int i = 0; i < N; i++) begin
            if (valid[i] &&
                (!found || pri[i*PRI_WIDTH +: PRI_WIDTH] < best_pri)) begin
                found    = 1'b1;
                best_pri = pri[i*PRI_WIDTH +: PRI_WIDTH];
                id       = ID_WIDTH'(i);
            end
        end
    end

endmodule

// File: rtl/jelly_rtos_semaphore_bank.sv
// Bank of counting semaphores with per-task wait slots.
// Define JELLY_RTOS_SEMAPHORE_TIMEOUT_EN for tick-driven wait timeouts.
module jelly_rtos_semaphore_bank
    import jelly_rtos_pkg::*;
#(
    parameter int TASKS        = 16,
    parameter int SEMAPHORES   = 16,
    parameter int TSKPRI_WIDTH = 4,
    parameter int SEMCNT_WIDTH = 4,
    parameter int RELTIM_WIDTH = 16,
    parameter int INIT_COUNTER = 0,
    parameter int TSKID_WIDTH  = $clog2(TASKS),
    parameter int SEMID_WIDTH  = $clog2(SEMAPHORES)
) (
    input  logic                               clk,
    input  logic                               reset_n,
    input  logic                               cke,
    input  logic [1:0]                         cmd_op,
    input  logic [SEMID_WIDTH-1:0]             cmd_semid,
    input  logic [TSKID_WIDTH-1:0]             cmd_tskid,
    input  logic [TSKPRI_WIDTH-1:0]            cmd_tskpri,
    input  logic [RELTIM_WIDTH-1:0]            cmd_tmo,
    input  logic                               cmd_valid,
    output logic                               cmd_ready,
    input  logic                               tick,
    output logic [1:0]                         rsp_code,
    output logic                               rsp_valid,
    output logic [TSKID_WIDTH-1:0]             wakeup_tskid,
    output logic [1:0]                         wakeup_code,
    output logic                               wakeup_valid,
    output logic [SEMAPHORES*SEMCNT_WIDTH-1:0] sem_counter
);

    localparam logic [SEMCNT_WIDTH-1:0] CNT_INIT = SEMCNT_WIDTH'(INIT_COUNTER);

    logic [TASKS-1:0]        wvalid_q, wvalid_d;
    logic [SEMID_WIDTH-1:0]  wsemid_q [TASKS];
    logic [SEMID_WIDTH-1:0]  wsemid_d [TASKS];
    logic [TSKPRI_WIDTH-1:0] wpri_q   [TASKS];
    logic [TSKPRI_WIDTH-1:0] wpri_d   [TASKS];
    logic [SEMCNT_WIDTH-1:0] cnt_q    [SEMAPHORES];
    logic [SEMCNT_WIDTH-1:0] cnt_d    [SEMAPHORES];

    rsp_code_e              rsp_code_q, rsp_code_d;
    logic                   rsp_valid_q, rsp_valid_d;
    logic [TSKID_WIDTH-1:0] wakeup_tskid_q, wakeup_tskid_d;
    wup_code_e              wakeup_code_q, wakeup_code_d;
    logic                   wakeup_valid_q, wakeup_valid_d;

    logic [TASKS-1:0]              live;
    logic [TASKS-1:0]              sig_mask;
    logic [TASKS*TSKPRI_WIDTH-1:0] sig_pri;
    logic [TSKID_WIDTH-1:0]        sig_id;
    logic                          sig_found;
    logic [SEMCNT_WIDTH-1:0]       cnt_cur;
    cmd_op_e                       op;

`ifdef JELLY_RTOS_SEMAPHORE_TIMEOUT_EN
    localparam logic [RELTIM_WIDTH-1:0] TMO_INF = TMO_FEVR[RELTIM_WIDTH-1:0];

    logic [RELTIM_WIDTH-1:0] wtmo_q [TASKS];
    logic [RELTIM_WIDTH-1:0] wtmo_d [TASKS];
    logic [TASKS-1:0]        expired_q, expired_d;
    logic [TSKID_WIDTH-1:0]  drn_id;
    logic                    drn_found;

    assign live = wvalid_q & ~expired_q;

    jelly_rtos_pri_select #(
        .N         (TASKS),
        .PRI_WIDTH (TSKPRI_WIDTH),
        .ID_WIDTH  (TSKID_WIDTH)
    ) u_drain_sel (
        .valid (expired_q),
        .pri   ('0),
        .id    (drn_id),
        .found (drn_found)
    );
`else
    logic unused_tick;

    assign unused_tick = tick;
    assign live        = wvalid_q;
`endif

    always_comb begin
        sig_mask = '0;
        sig_pri  = '0;
        for (int i = 0; i < TASKS; i++) begin
            sig_mask[i] = live[i] && (wsemid_q[i] == cmd_semid);
            sig_pri[i*TSKPRI_WIDTH +: TSKPRI_WIDTH] = wpri_q[i];
        end
    end

    jelly_rtos_pri_select #(
        .N         (TASKS),
        .PRI_WIDTH (TSKPRI_WIDTH),
        .ID_WIDTH  (TSKID_WIDTH)
    ) u_signal_sel (
        .valid (sig_mask),
        .pri   (sig_pri),
        .id    (sig_id),
        .found (sig_found)
    );

    assign op      = cmd_op_e'(cmd_op);
    assign cnt_cur = cnt_q[cmd_semid];

    always_comb begin
        wvalid_d       = wvalid_q;
        wsemid_d       = wsemid_q;
        wpri_d         = wpri_q;
        cnt_d          = cnt_q;
        rsp_code_d     = RSP_OK;
        rsp_valid_d    = 1'b0;
        wakeup_tskid_d = '0;
        wakeup_code_d  = WUP_SIGNALED;
        wakeup_valid_d = 1'b0;
`ifdef JELLY_RTOS_SEMAPHORE_TIMEOUT_EN
        wtmo_d         = wtmo_q;
        expired_d      = expired_q;
        if (tick) begin
            for (int i = 0; i < TASKS; i++) begin
                if (live[i] && wtmo_q[i] != TMO_INF) begin
                    wtmo_d[i] = wtmo_q[i] - RELTIM_WIDTH'(1);
                    if (wtmo_q[i] == RELTIM_WIDTH'(1)) begin
                        expired_d[i] = 1'b1;
                    end
                end
            end
        end
`endif
        if (cmd_valid) begin
            rsp_valid_d = 1'b1;
            unique case (op)
                OP_SIGNAL: begin
                    if (sig_found) begin
                        wvalid_d[sig_id] = 1'b0;
                        wakeup_tskid_d   = sig_id;
                        wakeup_code_d    = WUP_SIGNALED;
                        wakeup_valid_d   = 1'b1;
                    end else if (&cnt_cur) begin
                        rsp_code_d = RSP_ERROR;
                    end else begin
                        cnt_d[cmd_semid] = cnt_cur + SEMCNT_WIDTH'(1);
                    end
                end
                OP_WAIT: begin
                    if (wvalid_q[cmd_tskid]) begin
                        rsp_code_d = RSP_ERROR;
                    end else if (cnt_cur != '0) begin
                        cnt_d[cmd_semid] = cnt_cur - SEMCNT_WIDTH'(1);
                    end else if (cmd_tmo == '0) begin
                        rsp_code_d = RSP_FAIL;
                    end else begin
                        wvalid_d[cmd_tskid] = 1'b1;
                        wsemid_d[cmd_tskid] = cmd_semid;
                        wpri_d[cmd_tskid]   = cmd_tskpri;
`ifdef JELLY_RTOS_SEMAPHORE_TIMEOUT_EN
                        wtmo_d[cmd_tskid]    = cmd_tmo;
                        expired_d[cmd_tskid] = 1'b0;
`endif
                        rsp_code_d = RSP_QUEUED;
                    end
                end
                OP_POLL: begin
                    if (cnt_cur != '0) begin
                        cnt_d[cmd_semid] = cnt_cur - SEMCNT_WIDTH'(1);
                    end else begin
                        rsp_code_d = RSP_FAIL;
                    end
                end
                OP_CANCEL: begin
                    if (live[cmd_tskid] && wsemid_q[cmd_tskid] == cmd_semid) begin
                        wvalid_d[cmd_tskid] = 1'b0;
                        wakeup_tskid_d      = cmd_tskid;
                        wakeup_code_d       = WUP_CANCELED;
                        wakeup_valid_d      = 1'b1;
                    end else begin
                        rsp_code_d = RSP_FAIL;
                    end
                end
            endcase
        end
`ifdef JELLY_RTOS_SEMAPHORE_TIMEOUT_EN
        // Expired slots drain only when no command wakeup owns the port.
        if (!wakeup_valid_d && drn_found) begin
            wvalid_d[drn_id]  = 1'b0;
            expired_d[drn_id] = 1'b0;
            wakeup_tskid_d    = drn_id;
            wakeup_code_d     = WUP_TIMEOUT;
            wakeup_valid_d    = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wvalid_q       <= '0;
            rsp_code_q     <= RSP_OK;
            rsp_valid_q    <= 1'b0;
            wakeup_tskid_q <= '0;
            wakeup_code_q  <= WUP_SIGNALED;
            wakeup_valid_q <= 1'b0;
            for (int i = 0; i < TASKS; i++) begin
                wsemid_q[i] <= '0;
                wpri_q[i]   <= '0;
            end
            for (int s = 0; s < SEMAPHORES; s++) begin
                cnt_q[s] <= CNT_INIT;
            end
`ifdef JELLY_RTOS_SEMAPHORE_TIMEOUT_EN
            expired_q <= '0;
            for (int i = 0; i < TASKS; i++) begin
                wtmo_q[i] <= '0;
            end
`endif
        end else if (cke) begin
            wvalid_q       <= wvalid_d;
            wsemid_q       <= wsemid_d;
            wpri_q         <= wpri_d;
            cnt_q          <= cnt_d;
            rsp_code_q     <= rsp_code_d;
            rsp_valid_q    <= rsp_valid_d;
            wakeup_tskid_q <= wakeup_tskid_d;
            wakeup_code_q  <= wakeup_code_d;
            wakeup_valid_q <= wakeup_valid_d;
`ifdef JELLY_RTOS_SEMAPHORE_TIMEOUT_EN
            wtmo_q         <= wtmo_d;
            expired_q      <= expired_d;
`endif
        end
    end

    always_comb begin
        sem_counter = '0;
        for (int s = 0; s < SEMAPHORES; s++) begin
            sem_counter[s*SEMCNT_WIDTH +: SEMCNT_WIDTH] = cnt_q[s];
        end
    end

    assign cmd_ready    = reset_n;
    assign rsp_code     = rsp_code_q;
    assign rsp_valid    = rsp_valid_q;
    assign wakeup_tskid = wakeup_tskid_q;
    assign wakeup_code  = wakeup_code_q;
    assign wakeup_valid = wakeup_valid_q;

endmodule

// File: tb/tb_jelly_rtos_semaphore_bank.sv
// Directed bench for the semaphore bank (INIT_COUNTER = 2).
// Covers poll, priority wake, saturation, cancel, timeout and reset.
module tb_jelly_rtos_semaphore_bank;
    import jelly_rtos_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cke;
    logic [1:0]  cmd_op;
    logic [3:0]  cmd_semid;
    logic [3:0]  cmd_tskid;
    logic [3:0]  cmd_tskpri;
    logic [15:0] cmd_tmo;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        tick;
    logic [1:0]  rsp_code;
    logic        rsp_valid;
    logic [3:0]  wakeup_tskid;
    logic [1:0]  wakeup_code;
    logic        wakeup_valid;
    logic [63:0] sem_counter;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    jelly_rtos_semaphore_bank #(
        .TASKS        (16),
        .SEMAPHORES   (16),
        .TSKPRI_WIDTH (4),
        .SEMCNT_WIDTH (4),
        .RELTIM_WIDTH (16),
        .INIT_COUNTER (2)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .cke          (cke),
        .cmd_op       (cmd_op),
        .cmd_semid    (cmd_semid),
        .cmd_tskid    (cmd_tskid),
        .cmd_tskpri   (cmd_tskpri),
        .cmd_tmo      (cmd_tmo),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .tick         (tick),
        .rsp_code     (rsp_code),
        .rsp_valid    (rsp_valid),
        .wakeup_tskid (wakeup_tskid),
        .wakeup_code  (wakeup_code),
        .wakeup_valid (wakeup_valid),
        .sem_counter  (sem_counter)
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] cnt(input int s);
        return 4'(sem_counter >> (s * 4));
    endfunction

    task automatic cmd(input logic [1:0] op, input int sem, input int tsk,
                       input int pri, input int tmo);
        @(negedge clk);
        cmd_op     = op;
        cmd_semid  = 4'(sem);
        cmd_tskid  = 4'(tsk);
        cmd_tskpri = 4'(pri);
        cmd_tmo    = 16'(tmo);
        cmd_valid  = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_tick();
        @(negedge clk);
        tick = 1'b1;
        @(posedge clk);
        #1;
        tick = 1'b0;
    endtask

    task automatic exp_rsp(input string tag, input logic [1:0] code);
        check({tag, ".rv"}, rsp_valid, 1'b1);
        check({tag, ".rc"}, rsp_code, code);
    endtask

    task automatic exp_wk(input string tag, input logic v, input int id,
                          input logic [1:0] code);
        check({tag, ".wv"}, wakeup_valid, v);
        if (v) begin
            check({tag, ".wid"}, wakeup_tskid, 4'(id));
            check({tag, ".wc"}, wakeup_code, code);
        end
    endtask

    initial begin
        reset_n   = 1'b0;
        cke       = 1'b1;
        cmd_op    = '0;
        cmd_semid = '0;
        cmd_tskid = '0;
        cmd_tskpri = '0;
        cmd_tmo   = '0;
        cmd_valid = 1'b0;
        tick      = 1'b0;
        step();
        step();
        check("rst.ready", cmd_ready, 1'b0);
        check("rst.rv", rsp_valid, 1'b0);
        check("rst.wv", wakeup_valid, 1'b0);
        check("rst.cnt", sem_counter, {16{4'd2}});
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        check("ready", cmd_ready, 1'b1);

        // poll down from the initial count
        cmd(OP_POLL, 3, 0, 0, 0); exp_rsp("poll1", RSP_OK);
        cmd(OP_POLL, 3, 0, 0, 0); exp_rsp("poll2", RSP_OK);
        cmd(OP_POLL, 3, 0, 0, 0); exp_rsp("poll3", RSP_FAIL);
        check("poll.cnt", cnt(3), 4'd0);

        // clock enable low freezes everything
        step();
        @(negedge clk);
        cke = 1'b0;
        cmd(OP_SIGNAL, 7, 0, 0, 0);
        check("cke.rv", rsp_valid, 1'b0);
        check("cke.cnt", cnt(7), 4'd2);
        cke = 1'b1;

        // wait succeeds immediately when the count is nonzero
        cmd(OP_WAIT, 6, 1, 0, 5); exp_rsp("wait.ok", RSP_OK);
        check("wait.ok.cnt", cnt(6), 4'd1);

        // priority wake on sem 1
        cmd(OP_POLL, 1, 0, 0, 0);
        cmd(OP_POLL, 1, 0, 0, 0);
        cmd(OP_WAIT, 1, 5, 3, 16'hFFFF); exp_rsp("pw.w5", RSP_QUEUED);
        cmd(OP_WAIT, 1, 2, 3, 16'hFFFF); exp_rsp("pw.w2", RSP_QUEUED);
        cmd(OP_WAIT, 1, 7, 1, 16'hFFFF); exp_rsp("pw.w7", RSP_QUEUED);
        cmd(OP_SIGNAL, 1, 0, 0, 0); exp_rsp("pw.s1", RSP_OK);
        exp_wk("pw.s1", 1'b1, 7, WUP_SIGNALED);
        cmd(OP_SIGNAL, 1, 0, 0, 0); exp_rsp("pw.s2", RSP_OK);
        exp_wk("pw.s2", 1'b1, 2, WUP_SIGNALED);
        cmd(OP_SIGNAL, 1, 0, 0, 0); exp_rsp("pw.s3", RSP_OK);
        exp_wk("pw.s3", 1'b1, 5, WUP_SIGNALED);
        check("pw.cnt", cnt(1), 4'd0);

        // saturation on sem 8
        cmd(OP_POLL, 8, 0, 0, 0);
        cmd(OP_POLL, 8, 0, 0, 0);
        for (int k = 0; k < 15; k++) begin
            cmd(OP_SIGNAL, 8, 0, 0, 0);
            exp_rsp("sat.sig", RSP_OK);
        end
        check("sat.cnt15", cnt(8), 4'd15);
        cmd(OP_SIGNAL, 8, 0, 0, 0); exp_rsp("sat.err", RSP_ERROR);
        check("sat.hold", cnt(8), 4'd15);

        // zero timeout, duplicate wait, cancel on sem 0
        cmd(OP_POLL, 0, 0, 0, 0);
        cmd(OP_POLL, 0, 0, 0, 0);
        cmd(OP_WAIT, 0, 1, 0, 0); exp_rsp("tmo0", RSP_FAIL);
        cmd(OP_WAIT, 0, 4, 0, 5); exp_rsp("dup.w1", RSP_QUEUED);
        cmd(OP_WAIT, 0, 4, 0, 5); exp_rsp("dup.w2", RSP_ERROR);
        cmd(OP_CANCEL, 0, 4, 0, 0); exp_rsp("can1", RSP_OK);
        exp_wk("can1", 1'b1, 4, WUP_CANCELED);
        cmd(OP_CANCEL, 0, 4, 0, 0); exp_rsp("can2", RSP_FAIL);
        exp_wk("can2", 1'b0, 0, 0);

        // timeout behaviour on sem 2
        cmd(OP_POLL, 2, 0, 0, 0);
        cmd(OP_POLL, 2, 0, 0, 0);
`ifdef JELLY_RTOS_SEMAPHORE_TIMEOUT_EN
        cmd(OP_WAIT, 2, 3, 2, 2); exp_rsp("to.w3", RSP_QUEUED);
        cmd(OP_WAIT, 2, 6, 1, 2); exp_rsp("to.w6", RSP_QUEUED);
        do_tick(); exp_wk("to.t1", 1'b0, 0, 0);
        do_tick(); exp_wk("to.t2", 1'b0, 0, 0);
        cmd(OP_SIGNAL, 2, 0, 0, 0); exp_rsp("to.sig", RSP_OK);
        exp_wk("to.d3", 1'b1, 3, WUP_TIMEOUT);
        check("to.cnt", cnt(2), 4'd1);
        step(); exp_wk("to.d6", 1'b1, 6, WUP_TIMEOUT);
        step(); exp_wk("to.idle", 1'b0, 0, 0);
`else
        cmd(OP_WAIT, 2, 3, 2, 2); exp_rsp("nt.w3", RSP_QUEUED);
        do_tick(); exp_wk("nt.t1", 1'b0, 0, 0);
        do_tick(); exp_wk("nt.t2", 1'b0, 0, 0);
        do_tick(); exp_wk("nt.t3", 1'b0, 0, 0);
        cmd(OP_SIGNAL, 2, 0, 0, 0); exp_rsp("nt.sig", RSP_OK);
        exp_wk("nt.sig", 1'b1, 3, WUP_SIGNALED);
        check("nt.cnt", cnt(2), 4'd0);
`endif

        // reset right after a queuing wait on sem 4
        cmd(OP_POLL, 4, 0, 0, 0);
        cmd(OP_POLL, 4, 0, 0, 0);
        cmd(OP_WAIT, 4, 9, 0, 16'hFFFF); exp_rsp("mr.w9", RSP_QUEUED);
        @(negedge clk);
        reset_n = 1'b0;
        step();
        check("mr.rv", rsp_valid, 1'b0);
        check("mr.rc", rsp_code, 2'd0);
        check("mr.wv", wakeup_valid, 1'b0);
        check("mr.ready", cmd_ready, 1'b0);
        check("mr.cnt", sem_counter, {16{4'd2}});
        @(negedge clk);
        reset_n = 1'b1;
        cmd(OP_SIGNAL, 4, 0, 0, 0); exp_rsp("mr.sig", RSP_OK);
        exp_wk("mr.sig", 1'b0, 0, 0);
        check("mr.cnt4", cnt(4), 4'd3);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
